// File: rtl/icache_pkg.sv
// Shared types and widths for the N-way set-associative instruction cache.
package icache_pkg;

  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int ADDR_W         = 30;
  localparam int LINE_ADDR_W    = 28;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE,
    ALLOC,
    REFILL
  } state_e;

  // Extract word 'sel' from a line; word k sits at bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        sel);
    return line[sel*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_nway_if.sv
// Fetch-port and line-memory bus between the pipeline, the cache and memory.
interface icache_nway_if;
  import icache_pkg::*;

  logic                   proc_read;
  logic [ADDR_W-1:0]      proc_addr;
  logic                   proc_flush;
  logic [WORD_W-1:0]      proc_rdata;
  logic                   proc_stall;

  logic                   mem_read;
  logic [LINE_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]      mem_rdata;
  logic                   mem_ready;

  // The cache is the slave of the fetch port and the master of memory.
  modport slave (
    input  proc_read, proc_addr, proc_flush, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr
  );

  modport master (
    output proc_read, proc_addr, proc_flush, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr
  );

endinterface

// File: rtl/icache_victim_sel.sv
// Per-set round-robin pointers and invalid-first victim selection.
module icache_victim_sel #(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 4,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             proc_reset_n,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [WAYS-1:0]  set_valid,
  input  logic             refill,
  input  logic             flush,
  output logic [WAY_W-1:0] victim
);

  logic [WAY_W-1:0] ptr_q [SETS];
  logic [WAY_W-1:0] ptr_d [SETS];
  logic             any_invalid;
  logic [WAY_W-1:0] first_invalid;

  // Scan from the top so the lowest-index invalid way wins.
  always_comb begin
    any_invalid   = 1'b0;
    first_invalid = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) begin
        any_invalid   = 1'b1;
        first_invalid = WAY_W'(w);
      end
    end
    victim = any_invalid ? first_invalid : ptr_q[set_idx];
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      for (int s = 0; s < SETS; s++) ptr_d[s] = '0;
    end else if (refill && !any_invalid) begin
      ptr_d[set_idx] = (ptr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[set_idx] + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with round-robin
// replacement, whole-cache flush and saturating hit/miss counters.
module icache_nway
  import icache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             proc_reset_n,
  icache_nway_if.slave     bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = LINE_ADDR_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e            state_q, state_d;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   valid_d [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic              flush_pend_q, flush_pend_d;
  logic [LINE_W-1:0] line_buf_q, line_buf_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  set_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [1:0]        word_sel;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              flush_now;
  logic              fill_we;

  assign set_idx      = bus.proc_addr[IDX_W+1:2];
  assign req_tag      = bus.proc_addr[ADDR_W-1:IDX_W+2];
  assign word_sel     = bus.proc_addr[1:0];
  assign bus.mem_addr = bus.proc_addr[ADDR_W-1:2];
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;

  // Tags are unique within a set, so at most one way matches.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  icache_victim_sel #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_victim_sel (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .set_idx      (set_idx),
    .set_valid    (valid_q[set_idx]),
    .refill       (fill_we),
    .flush        (flush_now),
    .victim       (victim)
  );

  always_comb begin
    state_d        = state_q;
    flush_pend_d   = flush_pend_q;
    line_buf_d     = line_buf_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    flush_now      = 1'b0;
    fill_we        = 1'b0;
    bus.proc_stall = 1'b0;
    bus.mem_read   = 1'b0;
    bus.proc_rdata = '0;

    unique case (state_q)
      IDLE: begin
        if (flush_pend_q) begin
          // A flush deferred from a refill costs exactly one stall cycle here.
          bus.proc_stall = 1'b1;
          flush_now      = 1'b1;
          flush_pend_d   = 1'b0;
        end else begin
          if (bus.proc_read && hit) begin
            bus.proc_rdata = line_word(data_q[set_idx][hit_way], word_sel);
            hit_cnt_d      = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;
          end else if (bus.proc_read) begin
            bus.proc_stall = 1'b1;
            bus.mem_read   = 1'b1;
            state_d        = ALLOC;
            miss_cnt_d     = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 1'b1;
          end
          flush_now = bus.proc_flush;
        end
      end
      ALLOC: begin
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b1;
        if (bus.mem_ready) begin
          line_buf_d = bus.mem_rdata;
          state_d    = REFILL;
        end
        if (bus.proc_flush) flush_pend_d = 1'b1;
      end
      REFILL: begin
        bus.proc_stall = 1'b1;
        fill_we        = 1'b1;
        state_d        = IDLE;
        if (bus.proc_flush) flush_pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid bits and tags change only at REFILL, so a half-filled line never hits.
  always_comb begin
    valid_d = valid_q;
    if (flush_now) begin
      for (int s = 0; s < SETS; s++) valid_d[s] = '0;
    end else if (fill_we) begin
      valid_d[set_idx][victim] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      line_buf_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      line_buf_q   <= line_buf_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      valid_q      <= valid_d;
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[set_idx][victim]  <= req_tag;
      data_q[set_idx][victim] <= line_buf_q;
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench: a 2-way/4-set cache and a 4-way/16-set cache with 3-bit
// counters, driven from one shared stimulus path selected by 'sel'.
module tb_icache_nway;

  logic clk;
  logic rst_n;
  logic sel;

  logic          drv_read;
  logic [29:0]   drv_addr;
  logic          drv_flush;
  logic [127:0]  drv_rdata;
  logic          drv_ready;

  logic          o_stall;
  logic [31:0]   o_rdata;
  logic          o_mem_read;
  logic [27:0]   o_mem_addr;

  logic [31:0]   hit2, miss2;
  logic [2:0]    hit4, miss4;

  int vectors;
  int miscompares;

  icache_nway_if bus2 ();
  icache_nway_if bus4 ();

  assign bus2.proc_read  = drv_read & ~sel;
  assign bus2.proc_addr  = drv_addr;
  assign bus2.proc_flush = drv_flush & ~sel;
  assign bus2.mem_rdata  = drv_rdata;
  assign bus2.mem_ready  = drv_ready & ~sel;

  assign bus4.proc_read  = drv_read & sel;
  assign bus4.proc_addr  = drv_addr;
  assign bus4.proc_flush = drv_flush & sel;
  assign bus4.mem_rdata  = drv_rdata;
  assign bus4.mem_ready  = drv_ready & sel;

  assign o_stall    = sel ? bus4.proc_stall : bus2.proc_stall;
  assign o_rdata    = sel ? bus4.proc_rdata : bus2.proc_rdata;
  assign o_mem_read = sel ? bus4.mem_read   : bus2.mem_read;
  assign o_mem_addr = sel ? bus4.mem_addr   : bus2.mem_addr;

  icache_nway #(.WAYS(2), .SETS(4), .CNT_W(32)) u_dut2 (
    .clk          (clk),
    .proc_reset_n (rst_n),
    .bus          (bus2),
    .hit_cnt      (hit2),
    .miss_cnt     (miss2)
  );

  icache_nway #(.WAYS(4), .SETS(16), .CNT_W(3)) u_dut4 (
    .clk          (clk),
    .proc_reset_n (rst_n),
    .bus          (bus4),
    .hit_cnt      (hit4),
    .miss_cnt     (miss4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents: one hand-picked line, otherwise {line_addr, word index}.
  function automatic logic [127:0] line_for(input logic [27:0] la);
    if (la == 28'h4) return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    return {la, 4'd3, la, 4'd2, la, 4'd1, la, 4'd0};
  endfunction

  function automatic logic [31:0] exp_word(input logic [29:0] a);
    logic [127:0] l;
    l = line_for(a[29:2]);
    return l[a[1:0]*32 +: 32];
  endfunction

  // One fetch: counts stall cycles, answers mem_read after 'delay' extra
  // ALLOC cycles, optionally drops the request and/or flushes in ALLOC.
  task automatic do_read(input logic [29:0] addr, input int delay, input bit drop,
                         input bit flush_in_alloc, output int stalls, output logic [31:0] word);
    int mr_cycles;
    bit done;
    stalls    = 0;
    mr_cycles = 0;
    word      = '0;
    done      = 1'b0;
    @(negedge clk);
    drv_read = 1'b1;
    drv_addr = addr;
    while (!done) begin
      #1;
      if (!o_stall) begin
        word = o_rdata;
        done = 1'b1;
      end else begin
        stalls++;
        if (o_mem_read) begin
          mr_cycles++;
          if (mr_cycles == delay + 2) begin
            drv_ready = 1'b1;
            drv_rdata = line_for(o_mem_addr);
          end
        end
        if (stalls > 40) begin
          check("stall_timeout", stalls, 40);
          done = 1'b1;
        end else begin
          @(negedge clk);
          drv_ready = 1'b0;
          drv_flush = 1'b0;
          if (mr_cycles == 1) begin
            if (drop) drv_read = 1'b0;
            if (flush_in_alloc) drv_flush = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    drv_read  = 1'b0;
    drv_ready = 1'b0;
    drv_flush = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [29:0] addr, input int exp_stalls,
                          input int delay = 0, input bit drop = 1'b0, input bit fl = 1'b0);
    int          stalls;
    logic [31:0] word;
    do_read(addr, delay, drop, fl, stalls, word);
    check({tag, "_stalls"}, stalls, exp_stalls);
    check({tag, "_rdata"}, word, drop ? 32'h0 : exp_word(addr));
  endtask

  task automatic do_flush();
    @(negedge clk);
    drv_read  = 1'b0;
    drv_flush = 1'b1;
    @(negedge clk);
    drv_flush = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sel         = 1'b0;
    rst_n       = 1'b0;
    drv_read    = 1'b0;
    drv_addr    = '0;
    drv_flush   = 1'b0;
    drv_rdata   = '0;
    drv_ready   = 1'b0;
    #1;
    check("reset_stall", o_stall, 1'b0);
    check("reset_mem_read", o_mem_read, 1'b0);
    check("reset_rdata", o_rdata, 32'h0);
    #20 rst_n = 1'b1;
    check("reset_hit_cnt", hit2, 32'd0);
    check("reset_miss_cnt", miss2, 32'd0);

    // Cold miss then same-line hit.
    rd_check("cold_miss", 30'h10, 3);
    rd_check("cold_hit", 30'h13, 0);
    check("cold_hit_cnt", hit2, 32'd2);
    check("cold_miss_cnt", miss2, 32'd1);

    // Set 0: invalid-first fill, then round-robin eviction.
    rd_check("rr_tag2", 30'h20, 3);
    rd_check("rr_tag3", 30'h30, 3);
    rd_check("rr_tag4", 30'h40, 3);
    rd_check("rr_tag3_hit", 30'h31, 0);
    rd_check("rr_tag4_hit", 30'h42, 0);
    rd_check("rr_tag1_gone", 30'h10, 3);
    rd_check("rr_tag4_kept", 30'h43, 0);
    rd_check("rr_tag3_gone", 30'h30, 3);

    // Slow memory with the request dropped in ALLOC.
    rd_check("slow_refill", 30'h25, 8, 5, 1'b1);
    rd_check("slow_line_hit", 30'h25, 0);

    // Flush in IDLE.
    do_flush();
    rd_check("flush_idle_miss", 30'h25, 3);

    // Flush in ALLOC: refill completes, one extra stall, then the line is gone.
    rd_check("flush_alloc", 30'h38, 4, 0, 1'b1, 1'b1);
    rd_check("flush_alloc_miss", 30'h38, 3);

    // Reset in the middle of ALLOC.
    @(negedge clk);
    drv_read = 1'b1;
    drv_addr = 30'h0C;
    #1 check("rst_idle_mem_read", o_mem_read, 1'b1);
    @(negedge clk);
    #1 check("rst_alloc_mem_read", o_mem_read, 1'b1);
    rst_n    = 1'b0;
    drv_read = 1'b0;
    #1 check("rst_async_mem_read", o_mem_read, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_hit_cnt", hit2, 32'd0);
    check("rst_miss_cnt", miss2, 32'd0);
    rd_check("rst_miss_a", 30'h13, 3);
    rd_check("rst_miss_b", 30'h0C, 3);
    rd_check("rst_refilled_hit", 30'h10, 0);
    check("rst_hit_cnt_after", hit2, 32'd3);
    check("rst_miss_cnt_after", miss2, 32'd2);

    // 4-way, 16-set build.
    sel = 1'b1;
    rd_check("w4_set1", 30'h44, 3);
    rd_check("w4_set2", 30'h48, 3);
    rd_check("w4_set3", 30'h4C, 3);
    rd_check("w4_t1", 30'h040, 3);
    rd_check("w4_t2", 30'h080, 3);
    rd_check("w4_t3", 30'h0C0, 3);
    rd_check("w4_t4", 30'h100, 3);
    rd_check("w4_t5", 30'h141, 3);
    rd_check("w4_t2_hit", 30'h081, 0);
    rd_check("w4_t3_hit", 30'h0C2, 0);
    rd_check("w4_t4_hit", 30'h103, 0);
    rd_check("w4_t5_hit", 30'h140, 0);
    rd_check("w4_set1_hit", 30'h45, 0);
    rd_check("w4_set2_hit", 30'h4A, 0);
    rd_check("w4_set3_hit", 30'h4F, 0);
    rd_check("w4_t1_evicted", 30'h040, 3);
    check("w4_hit_cnt_sat", hit4, 3'd7);
    check("w4_miss_cnt_sat", miss4, 3'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
